// File: rtl/ps2_mouse_position.sv
// Receive-only PS/2 mouse decoder: filters the device clock, frames 11-bit bytes,
// assembles 3-byte stream packets and keeps saturating 8-bit absolute X/Y.
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on a falling filtered clock)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then handing the byte to the packet logic
module ps2_mouse_position #(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] X_INIT         = 8'h80,
  parameter logic [7:0] Y_INIT         = 8'h80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] XPosition,
  output logic [7:0] YPosition,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, sample_evt, sample_bit;
  logic [FW-1:0] filt_cnt;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [6:0]    hdr, hdr_nxt;
  logic [7:0]    dx_byte, dx_byte_nxt;
  logic [7:0]    x_nxt, y_nxt;
  logic [2:0]    btn_nxt;
  logic          pv_nxt, fe_nxt;
  logic          timed_out, frame_good;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The strobe fires the cycle after the filtered level commits to 0, with the data
  // sample taken from the same synchronised cycle as the committing clock sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      filt_cnt   <= '0;
      sample_evt <= 1'b0;
      sample_bit <= 1'b1;
    end else begin
      sample_evt <= 1'b0;
      sample_bit <= data_sync[1];
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt   <= clk_sync[1];
        filt_cnt   <= '0;
        sample_evt <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  function automatic logic signed [9:0] delta(input logic sgn, input logic ovf,
                                               input logic [7:0] mag);
    if (ovf) return sgn ? -10'sd256 : 10'sd255;
    return $signed({sgn, sgn, mag});
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] pos, input logic signed [9:0] d);
    logic signed [9:0] sum;
    sum = $signed({2'b00, pos}) + d;
    if (sum < 10'sd0) return 8'h00;
    if (sum > 10'sd255) return 8'hFF;
    return sum[7:0];
  endfunction

  assign timed_out  = (timer == '0);
  assign frame_good = sample_bit && (^{shift, par});

  // hdr = {Yovf, Xovf, Ysign, Xsign, M, R, L}
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par;
    idx_nxt     = idx;
    hdr_nxt     = hdr;
    dx_byte_nxt = dx_byte;
    x_nxt       = XPosition;
    y_nxt       = YPosition;
    btn_nxt     = buttons;
    pv_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    timer_nxt   = timed_out ? timer : timer - TW'(1);
    if (sample_evt) timer_nxt = TW'(TIMEOUT_CYCLES);

    case (state)
      IDLE: begin
        if (sample_evt) begin
          if (!sample_bit) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end
        end else if (timed_out && idx != 2'd0) begin
          idx_nxt = 2'd0;
        end
      end
      DATA: begin
        if (sample_evt) begin
          shift_nxt   = {sample_bit, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end else if (timed_out) begin
          state_nxt = IDLE;
          fe_nxt    = 1'b1;
          idx_nxt   = 2'd0;
        end
      end
      PARITY: begin
        if (sample_evt) begin
          par_nxt   = sample_bit;
          state_nxt = STOP;
        end else if (timed_out) begin
          state_nxt = IDLE;
          fe_nxt    = 1'b1;
          idx_nxt   = 2'd0;
        end
      end
      STOP: begin
        if (sample_evt) begin
          state_nxt = IDLE;
          if (!frame_good) begin
            fe_nxt  = 1'b1;
            idx_nxt = 2'd0;
          end else begin
            case (idx)
              2'd0: begin
                if (!shift[3]) begin
                  fe_nxt = 1'b1;
                end else begin
                  hdr_nxt = {shift[7:4], shift[2:0]};
                  idx_nxt = 2'd1;
                end
              end
              2'd1: begin
                dx_byte_nxt = shift;
                idx_nxt     = 2'd2;
              end
              default: begin
                x_nxt   = clamp(XPosition, delta(hdr[3], hdr[5], dx_byte));
                y_nxt   = clamp(YPosition, delta(hdr[4], hdr[6], shift));
                btn_nxt = hdr[2:0];
                pv_nxt  = 1'b1;
                idx_nxt = 2'd0;
              end
            endcase
          end
        end else if (timed_out) begin
          state_nxt = IDLE;
          fe_nxt    = 1'b1;
          idx_nxt   = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      par          <= 1'b0;
      timer        <= '0;
      idx          <= 2'd0;
      hdr          <= 7'h00;
      dx_byte      <= 8'h00;
      XPosition    <= X_INIT;
      YPosition    <= Y_INIT;
      buttons      <= 3'b000;
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      par          <= par_nxt;
      timer        <= timer_nxt;
      idx          <= idx_nxt;
      hdr          <= hdr_nxt;
      dx_byte      <= dx_byte_nxt;
      XPosition    <= x_nxt;
      YPosition    <= y_nxt;
      buttons      <= btn_nxt;
      packet_valid <= pv_nxt;
      frame_error  <= fe_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_position.sv
// Directed bench for ps2_mouse_position: PS/2 frames driven bit by bit, outputs
// tracked every cycle against a packet-level position model.
`timescale 1ns/1ps
module tb_ps2_mouse_position;

  // 1 MHz system clock so an 80-cycle PS/2 bit is a real 12.5 kHz bit.
  logic clock = 1'b0;
  logic reset, ps2_clk, ps2_data;
  logic [7:0] XPosition, YPosition;
  logic [2:0] buttons;
  logic packet_valid, frame_error;

  always #500 clock = ~clock;

  ps2_mouse_position #(
    .FILTER_LEN(8), .TIMEOUT_CYCLES(2000), .X_INIT(8'h80), .Y_INIT(8'h80)
  ) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .XPosition(XPosition), .YPosition(YPosition), .buttons(buttons),
    .packet_valid(packet_valid), .frame_error(frame_error)
  );

  typedef struct {logic [7:0] x; logic [7:0] y; logic [2:0] b;} pos_t;

  pos_t q[$];
  pos_t cur;
  int mdl_x, mdl_y;
  int vectors, miscompares, pv_count, fe_count;
  int pv0, fe0;

  function automatic int mdelta(input logic sgn, input logic ovf, input logic [7:0] m);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(m) - 256 : int'(m);
  endfunction

  function automatic int mclamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Per-cycle compare: the DUT must show the model position, moving only on packet_valid.
  task automatic tick();
    pos_t p;
    @(negedge clock);
    if (packet_valid) begin
      pv_count++;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_packet_valid at %0t: got 1 want 0", $time);
      end else begin
        p = q.pop_front();
        cur = p;
      end
    end
    if (frame_error) fe_count++;
    vectors++;
    if (XPosition !== cur.x || YPosition !== cur.y || buttons !== cur.b) begin
      miscompares++;
      $display("FAIL track at %0t: got X=%h Y=%h B=%b want X=%h Y=%h B=%b",
               $time, XPosition, YPosition, buttons, cur.x, cur.y, cur.b);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    ticks(20);
    ps2_clk = 1'b0;
    ticks(40);
    ps2_clk = 1'b1;
    ticks(20);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    ticks(100);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    pos_t p;
    mdl_x = mclamp(mdl_x + mdelta(b0[4], b0[6], b1));
    mdl_y = mclamp(mdl_y + mdelta(b0[5], b0[7], b2));
    p.x = 8'(mdl_x);
    p.y = 8'(mdl_y);
    p.b = b0[2:0];
    q.push_back(p);
    send_byte(b0, 1'b0, 1'b0);
    send_byte(b1, 1'b0, 1'b0);
    send_byte(b2, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    cur.x = 8'h80;
    cur.y = 8'h80;
    cur.b = 3'b000;
    mdl_x = 'h80;
    mdl_y = 'h80;
    q.delete();
  endtask

  task automatic mark();
    pv0 = pv_count;
    fe0 = fe_count;
  endtask

  task automatic chk_pos(input string name, input int x, input int y, input int b);
    chk({name, "_x"}, int'(XPosition), x);
    chk({name, "_y"}, int'(YPosition), y);
    chk({name, "_btn"}, int'(buttons), b);
  endtask

  initial begin
    vectors = 0; miscompares = 0; pv_count = 0; fe_count = 0;
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    ticks(5);
    reset = 1'b1;
    ticks(5);
    chk_pos("reset", 'h80, 'h80, 0);
    chk("reset_pulses", pv_count + fe_count, 0);

    // basic packet from reset
    mark();
    send_packet(8'h09, 8'h10, 8'h05);
    chk_pos("pkt1", 'h90, 'h85, 1);
    chk("pkt1_pv", pv_count - pv0, 1);
    chk("pkt1_fe", fe_count - fe0, 0);

    // X overflow, positive: saturate high
    send_packet(8'h48, 8'h00, 8'h00);
    chk_pos("xovf", 'hFF, 'h85, 0);

    // reset with a partial packet in flight
    send_byte(8'h09, 1'b0, 1'b0);
    mark();
    reset = 1'b0;
    model_reset();
    ticks(5);
    chk_pos("midreset", 'h80, 'h80, 0);
    reset = 1'b1;
    ticks(5);
    chk("midreset_pulses", (pv_count - pv0) + (fe_count - fe0), 0);

    // dx = -256 clamps low, Y untouched
    send_packet(8'h18, 8'h00, 8'h00);
    chk_pos("clamp_lo", 'h00, 'h80, 0);

    // bad parity on byte1 drops the packet
    mark();
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0);
    chk("parity_fe", fe_count - fe0, 1);
    chk("parity_pv", pv_count - pv0, 0);
    send_packet(8'h08, 8'h01, 8'h01);
    chk_pos("after_parity", 'h01, 'h81, 0);

    // bad stop bit
    mark();
    send_byte(8'h08, 1'b0, 1'b1);
    chk("stop_fe", fe_count - fe0, 1);

    // clock stalls after 4 data bits
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    ticks(2600);
    chk("timeout_fe", fe_count - fe0, 1);
    chk("timeout_pv", pv_count - pv0, 0);
    send_packet(8'h09, 8'h05, 8'hFB);
    chk_pos("after_timeout", 'h06, 'hFF, 1);

    // header without bit3 rejected
    mark();
    send_byte(8'h01, 1'b0, 1'b0);
    chk("hdr_fe", fe_count - fe0, 1);
    chk("hdr_pv", pv_count - pv0, 0);
    send_packet(8'h28, 8'h02, 8'h03);
    chk_pos("neg_dy", 'h08, 'h02, 0);

    // long gap after a header silently restarts the packet
    mark();
    send_byte(8'h08, 1'b0, 1'b0);
    ticks(2600);
    send_packet(8'h0C, 8'h10, 8'h10);
    chk("gap_fe", fe_count - fe0, 0);
    chk("gap_pv", pv_count - pv0, 1);
    chk_pos("gap", 'h18, 'h12, 4);

    // Y overflow, negative: saturate low
    send_packet(8'hA8, 8'h00, 8'h00);
    chk_pos("yovf", 'h18, 'h00, 0);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
